// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC definitions: default width and sequencer state encoding
package mac_pkg;

    localparam int MAC_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT
    } mac_state_e;

endpackage

// File: rtl/mac_operand_fifo.sv
// rtl/mac_operand_fifo.sv - synchronous FIFO of {a,b} element pairs with fall-through read
module mac_operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_a,
    input  logic [WIDTH-1:0]       push_b,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_a,
    output logic [WIDTH-1:0]       pop_b,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_a   = mem_a_q[rd_ptr_q];
    assign pop_b   = mem_b_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Element storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_a_q[wr_ptr_q] <= push_a;
            mem_b_q[wr_ptr_q] <= push_b;
        end
    end

endmodule

// File: rtl/mac_pair_sequencer.sv
// rtl/mac_pair_sequencer.sv - feeds element pairs to the dual-product MAC and accumulates a dot product
module mac_pair_sequencer
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             mac_input_ready,
    output logic             mac_input_valid,
    output logic [WIDTH-1:0] mac_x,
    output logic [WIDTH-1:0] mac_y,
    output logic [WIDTH-1:0] mac_x2,
    output logic [WIDTH-1:0] mac_y2,
    output logic [WIDTH-1:0] mac_prev,
    input  logic             mac_output_valid,
    output logic             mac_output_ready,
    input  logic [WIDTH-1:0] mac_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    mac_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] accepted_q, accepted_d;
    logic [LEN_W-1:0] consumed_q, consumed_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, x2_q, x2_d, y2_q, y2_d;
    logic             half_q, half_d;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0]       fifo_a, fifo_b;
    logic [$clog2(DEPTH):0] fifo_count_unused;

    // Intake runs in every busy state so the FIFO prefetches while the MAC works.
    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = busy & ~fifo_full & (accepted_q < len_q);
    assign fifo_push = in_valid & in_ready;
    assign mac_x     = x_q;
    assign mac_y     = y_q;
    assign mac_x2    = x2_q;
    assign mac_y2    = y2_q;
    assign mac_prev  = '0;
    assign res_data  = acc_q;

    mac_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (fifo_push),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (fifo_pop),
        .pop_a  (fifo_a),
        .pop_b  (fifo_b),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count_unused)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        accepted_d       = accepted_q;
        consumed_d       = consumed_q;
        acc_d            = acc_q;
        x_d              = x_q;
        y_d              = y_q;
        x2_d             = x2_q;
        y2_d             = y2_q;
        half_d           = half_q;
        fifo_pop         = 1'b0;
        mac_input_valid  = 1'b0;
        mac_output_ready = 1'b0;
        res_valid        = 1'b0;
        done             = 1'b0;

        if (fifo_push) begin
            accepted_d = accepted_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = len;
                    acc_d      = '0;
                    accepted_d = '0;
                    consumed_d = '0;
                    half_d     = 1'b0;
                    state_d    = (len == '0) ? ST_EMIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    consumed_d = consumed_q + LEN_W'(1);
                    if (!half_q) begin
                        x_d  = fifo_a;
                        y_d  = fifo_b;
                        x2_d = '0;
                        y2_d = '0;
                        // An odd tail leaves the second product zeroed.
                        if (consumed_d == len_q) begin
                            state_d = ST_ISSUE;
                        end else begin
                            half_d = 1'b1;
                        end
                    end else begin
                        x2_d    = fifo_a;
                        y2_d    = fifo_b;
                        half_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mac_input_valid = 1'b1;
                if (mac_input_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mac_output_ready = 1'b1;
                if (mac_output_valid) begin
                    acc_d   = acc_q + mac_result;
                    state_d = (consumed_q == len_q) ? ST_EMIT : ST_LOAD;
                end
            end
            ST_EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            accepted_q <= '0;
            consumed_q <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            half_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            accepted_q <= accepted_d;
            consumed_q <= consumed_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            half_q     <= half_d;
        end
    end

endmodule

// File: tb/tb_mac_pair_sequencer.sv
// tb/tb_mac_pair_sequencer.sv - directed self-checking bench for mac_pair_sequencer
module tb_mac_pair_sequencer;

    logic        clock = 1'b0;
    logic        reset, start, in_valid, mac_input_ready, mac_output_valid, res_ready;
    logic [15:0] len;
    logic [31:0] in_a, in_b, mac_result;

    logic        busy, done, in_ready, mac_input_valid, mac_output_ready, res_valid;
    logic [31:0] mac_x, mac_y, mac_x2, mac_y2, mac_prev, res_data;

    logic        b8_busy, b8_done, b8_in_ready, b8_mac_input_valid, b8_mac_output_ready, b8_res_valid;
    logic [7:0]  b8_mac_x, b8_mac_y, b8_mac_x2, b8_mac_y2, b8_mac_prev, b8_res_data;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    mac_pair_sequencer #(.WIDTH(32), .DEPTH(4), .LEN_W(16)) u_dut (
        .clock(clock), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_input_ready(mac_input_ready), .mac_input_valid(mac_input_valid),
        .mac_x(mac_x), .mac_y(mac_y), .mac_x2(mac_x2), .mac_y2(mac_y2), .mac_prev(mac_prev),
        .mac_output_valid(mac_output_valid), .mac_output_ready(mac_output_ready),
        .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    mac_pair_sequencer #(.WIDTH(8), .DEPTH(4), .LEN_W(16)) u_dut8 (
        .clock(clock), .reset(reset), .start(start), .len(len), .busy(b8_busy), .done(b8_done),
        .in_valid(in_valid), .in_ready(b8_in_ready), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
        .mac_input_ready(mac_input_ready), .mac_input_valid(b8_mac_input_valid),
        .mac_x(b8_mac_x), .mac_y(b8_mac_y), .mac_x2(b8_mac_x2), .mac_y2(b8_mac_y2), .mac_prev(b8_mac_prev),
        .mac_output_valid(mac_output_valid), .mac_output_ready(b8_mac_output_ready),
        .mac_result(mac_result[7:0]), .res_valid(b8_res_valid), .res_ready(res_ready), .res_data(b8_res_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic mac_issue(input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] x2, input logic [31:0] y2, input int stall);
        int n = 0;
        while (!mac_input_valid && n < 50) begin
            tick();
            n++;
        end
        check("mac_input_valid", mac_input_valid, 1);
        check("mac_excl_issue", mac_output_ready, 0);
        check("mac_xy", {mac_x, mac_y}, {x, y});
        check("mac_x2y2", {mac_x2, mac_y2}, {x2, y2});
        check("mac_prev", mac_prev, 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_valid", mac_input_valid, 1);
            check("hold_xy", {mac_x, mac_y}, {x, y});
            check("hold_x2y2", {mac_x2, mac_y2}, {x2, y2});
        end
        mac_input_ready = 1'b1;
        tick();
        mac_input_ready = 1'b0;
        check("wait_out_ready", mac_output_ready, 1);
        check("mac_excl_wait", mac_input_valid, 0);
    endtask

    task automatic mac_finish(input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] x2, input logic [31:0] y2);
        mac_result       = x * y + x2 * y2;
        mac_output_valid = 1'b1;
        tick();
        mac_output_valid = 1'b0;
        mac_result       = '0;
    endtask

    task automatic emit(input logic [31:0] exp, input int stall);
        int n = 0;
        int d0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        check("res_valid", res_valid, 1);
        check("res_data", res_data, exp);
        check("done_early", done, 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp);
            check("hold_done", done, 0);
        end
        d0 = done_cnt;
        res_ready = 1'b1;
        #1;
        check("done_on_hs", done, 1);
        tick();
        res_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_res_valid", res_valid, 0);
        check("done_once", done_cnt, d0 + 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        mac_input_ready = 1'b0; mac_output_valid = 1'b0; mac_result = '0; res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mac_in_valid", mac_input_valid, 0);
        check("rst_mac_out_ready", mac_output_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_ops", {mac_x, mac_y, mac_x2, mac_y2} == '0, 1);
        check("rst_prev", mac_prev, 0);
        check("rst8_outs", {b8_busy, b8_done, b8_in_ready, b8_mac_input_valid, b8_mac_output_ready, b8_res_valid}, 0);
        check("rst8_data", {b8_mac_x, b8_mac_y, b8_mac_x2, b8_mac_y2, b8_mac_prev, b8_res_data}, 0);

        // Even length, plus a start pulse that must be ignored outside IDLE
        start_job(16'd4);
        start = 1'b1; len = 16'd7; tick(); start = 1'b0;
        feed(1, 5); feed(2, 6); feed(3, 7); feed(4, 8);
        mac_issue(1, 5, 2, 6, 0);
        mac_finish(1, 5, 2, 6);
        mac_issue(3, 7, 4, 8, 0);
        mac_finish(3, 7, 4, 8);
        emit(70, 0);

        // Odd length
        start_job(16'd3);
        feed(1, 4); feed(2, 5); feed(3, 6);
        mac_issue(1, 4, 2, 5, 0);
        mac_finish(1, 4, 2, 5);
        mac_issue(3, 6, 0, 0, 0);
        mac_finish(3, 6, 0, 0);
        emit(32, 0);

        // Zero length with result backpressure; offered elements must be refused
        start_job(16'd0);
        in_valid = 1'b1; in_a = 99; in_b = 99;
        check("zero_in_ready", in_ready, 0);
        check("zero_no_mac", mac_input_valid, 0);
        emit(0, 3);
        in_valid = 1'b0;

        // FIFO fill and MAC input backpressure
        start_job(16'd8);
        for (int k = 0; k < 6; k++) feed(k + 1, k + 10);
        in_valid = 1'b1; in_a = 7; in_b = 16;
        check("full_in_ready", in_ready, 0);
        check("full_flag", u_dut.u_fifo.full, 1);
        tick();
        check("full_in_ready2", in_ready, 0);
        mac_issue(1, 10, 2, 11, 5);
        mac_finish(1, 10, 2, 11);
        feed(7, 16);
        feed(8, 17);
        mac_issue(3, 12, 4, 13, 0);
        mac_finish(3, 12, 4, 13);
        mac_issue(5, 14, 6, 15, 0);
        in_valid = 1'b1; in_a = 9; in_b = 18;
        check("len_cap_not_full", u_dut.u_fifo.full, 0);
        check("len_cap_in_ready", in_ready, 0);
        mac_finish(5, 14, 6, 15);
        in_valid = 1'b0;
        mac_issue(7, 16, 8, 17, 0);
        mac_finish(7, 16, 8, 17);
        emit(528, 0);

        // Wrap on the 8-bit instance
        start_job(16'd2);
        feed(200, 1); feed(1, 100);
        mac_issue(200, 1, 1, 100, 0);
        check("w8_ops", {b8_mac_x, b8_mac_y, b8_mac_x2, b8_mac_y2}, {8'd200, 8'd1, 8'd1, 8'd100});
        mac_finish(200, 1, 1, 100);
        check("w8_res_valid", b8_res_valid, 1);
        check("w8_res_data", b8_res_data, 44);
        emit(300, 0);
        check("w8_done_seen", b8_busy, 0);

        // Reset mid-operation in WAIT
        start_job(16'd4);
        feed(9, 1); feed(9, 1); feed(9, 1); feed(9, 1);
        mac_issue(9, 1, 9, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_out_ready", mac_output_ready, 0);
        check("abort_fifo_empty", u_dut.u_fifo.empty, 1);
        check("abort_res_data", res_data, 0);
        start_job(16'd2);
        feed(2, 4); feed(3, 5);
        mac_issue(2, 4, 3, 5, 0);
        mac_finish(2, 4, 3, 5);
        emit(23, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_pair_sequencer.md
Name: mac_pair_sequencer

Overview:
- Upstream feeder and collector for the dual-product MAC MMIO unit.
- Accepts a stream of (a,b) element pairs for one dot product of programmable length and buffers them in a small FIFO.
- Packs elements two at a time onto the MAC's x/y/x2/y2 operands and drives its input handshake.
- Accumulates each MAC result locally; on completion, presents the final dot product on a ready/valid result port.

Parameters:
- WIDTH, 32, datapath width of elements, MAC operands and accumulator.
- DEPTH, 4, operand FIFO depth in elements. Power of two, minimum 2.
- LEN_W, 16, width of the length register.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a dot product; sampled only in IDLE
- len  in  LEN_W  element count, captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on result handshake
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid & in_ready
- in_a  in  WIDTH  activation element
- in_b  in  WIDTH  weight element
- mac_input_ready  in  1  MAC can accept operands
- mac_input_valid  out  1  operands valid
- mac_x, mac_y, mac_x2, mac_y2  out  WIDTH each  operand pair
- mac_prev  out  WIDTH  tied to 0
- mac_output_valid  in  1  MAC result valid
- mac_output_ready  out  1  sequencer accepts the MAC result
- mac_result  in  WIDTH  x*y + x2*y2 from the MAC
- res_valid  out  1  dot product valid
- res_ready  in  1  downstream accepts the result
- res_data  out  WIDTH  dot product

Behaviour:
- Reset clears FSM to IDLE, FIFO to empty, counters and accumulator to 0. All outputs read 0 after reset; mac_prev is always 0.
- Reset asserted mid-operation aborts immediately. No result is emitted. An in-flight MAC handshake is abandoned.
- Element intake: in_ready = busy & !fifo_full & (accepted < len_q).
  - This is independent of FSM state, so the FIFO prefetches while the MAC runs.
  - Push and pop in the same cycle are legal when the FIFO is full.
- FSM states:
  - IDLE: on start, capture len_q and clear acc, accepted, consumed. If len==0, go to EMIT; else go to LOAD.
  - LOAD: pop element 2k into x/y, then element 2k+1 into x2/y2, one pop per cycle while the FIFO is non-empty.
    - If the pair's second element index equals len_q (odd tail), x2=y2=0 and no second pop.
    - Once the pair is complete, go to ISSUE.
  - ISSUE: mac_input_valid=1. Operands are held stable until mac_input_ready is sampled high, then go to WAIT.
  - WAIT: mac_output_ready=1. On mac_output_valid, acc <= acc + mac_result (mod 2^WIDTH).
    - If consumed == len_q, go to EMIT; else go to LOAD.
  - EMIT: res_valid=1 and res_data=acc, held until res_ready. On the handshake, done pulses and the FSM returns to IDLE.
- mac_output_ready and mac_input_valid are never asserted in the same cycle.
- start outside IDLE is ignored. Elements beyond len_q are never accepted.
- Arithmetic: all sums truncate to WIDTH; no saturation and no overflow flag.
- Minimum cycles per pair with zero stalls: LOAD 2 + ISSUE 1 + MAC RUN 1 + WAIT 1.

Decomposition:
- Shared package (mac_pkg): the FSM state enum (IDLE, LOAD, ISSUE, WAIT, EMIT) and the default WIDTH constant, also used by the MAC wrapper.
- One sub-module, mac_operand_fifo:
  - Synchronous FIFO of {a,b}, DEPTH entries.
  - Ports: full, empty, push, pop, count.
  - Pointers wrap at DEPTH; supports simultaneous push/pop.

Test Plan:
- Even length: len=4, a=[1,2,3,4], b=[5,6,7,8], MAC always ready -> two MAC transactions with (1,5,2,6) and (3,7,4,8); res_data=70; one done pulse.
- Odd length: len=3, a=[1,2,3], b=[4,5,6] -> second transaction has x=3, y=6, x2=y2=0; res_data=32.
- Zero length: len=0 -> no MAC transaction; res_valid next cycle with res_data=0; in_ready stays 0.
- Backpressure:
  - mac_input_ready low for 5 cycles -> mac_input_valid held and operands unchanged.
  - res_ready low for 3 cycles -> res_valid and res_data held, done only on handshake.
  - in_valid driven continuously -> FIFO fills to DEPTH and in_ready drops.
- Wrap: WIDTH=8, len=2, a=[200,1], b=[1,100] -> res_data=44 (300 mod 256).
- Reset mid-op: assert reset while in WAIT of a len=4 job -> busy=0, res_valid=0, FIFO empty next cycle. A following len=2 job with a=[2,3], b=[4,5] yields 23.
